// File: rtl/exe_muldiv_unit.sv
// ---------------------------------------------------------------------------
// exe_muldiv_unit
//   Iterative multiply/divide unit for the EXE stage. A request is taken
//   with a valid/ready handshake. The unit computes one bit per cycle:
//   shift-add for multiply and restoring division for divide. It returns HI/LO
//   through a valid/ready response. Signed operations run on operand
//   magnitudes, and the sign is corrected on the last iteration.
//
// Ports
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   req_valid   request present
//   req_ready   unit can accept a request this cycle
//   req_op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   req_src1    multiplicand / dividend
//   req_src2    multiplier / divisor
//   cancel      flush; aborts any in-flight or pending operation
//   resp_valid  result available
//   resp_ready  consumer takes result
//   resp_hi     MUL: product high word; DIV: remainder
//   resp_lo     MUL: product low word;  DIV: quotient
//   busy        unit is not idle
// ---------------------------------------------------------------------------
module exe_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            cancel,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_hi,
    output logic [XLEN-1:0] resp_lo,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_div;
    logic              r_neg_q;      // product / quotient must be negated
    logic              r_neg_r;      // remainder must be negated (dividend negative)
    logic [XLEN-1:0]   r_opnd;       // multiplicand (MUL) or divisor (DIV) magnitude
    logic [XLEN-1:0]   r_src1;       // raw dividend, returned as-is on divide-by-zero
    logic [XLEN-1:0]   r_hi;         // partial product high / partial remainder
    logic [XLEN-1:0]   r_lo;         // multiplier bits / dividend bits + quotient
    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_hi;
    logic [XLEN-1:0]   r_resp_lo;

    // ---------------- request side ----------------
    logic              w_accept;
    logic              w_src1_neg;
    logic              w_src2_neg;
    logic [XLEN-1:0]   w_src1_mag;
    logic [XLEN-1:0]   w_src2_mag;

    // Gating with resetn keeps req_ready low while reset is held.
    assign req_ready  = (r_state == S_IDLE) & ~cancel & resetn;
    assign w_accept   = req_valid & req_ready;
    // op[0]==0 selects the signed variants.
    assign w_src1_neg = ~req_op[0] & req_src1[XLEN-1];
    assign w_src2_neg = ~req_op[0] & req_src2[XLEN-1];
    assign w_src1_mag = w_src1_neg ? -req_src1 : req_src1;
    assign w_src2_mag = w_src2_neg ? -req_src2 : req_src2;

    // ---------------- multiply step ----------------
    // The XLEN+1-bit sum keeps the carry, which shifts into the top of HI.
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN-1:0]   w_mul_hi;
    logic [XLEN-1:0]   w_mul_lo;

    assign w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {XLEN{1'b0}})};
    assign w_mul_hi  = w_mul_sum[XLEN:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[XLEN-1:1]};

    // ---------------- divide step ----------------
    // The shifted remainder is below 2*divisor, so bit XLEN of the
    // difference is a reliable borrow / sign indicator.
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_hi;
    logic [XLEN-1:0]   w_div_lo;

    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge    = ~w_div_diff[XLEN];
    assign w_div_hi    = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    assign w_div_lo    = {r_lo[XLEN-2:0], w_div_ge};

    // ---------------- step select and sign fix-up ----------------
    logic [XLEN-1:0]   w_step_hi;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fin_hi;
    logic [XLEN-1:0]   w_fin_lo;
    logic              w_last;
    logic              w_div_zero;

    assign w_step_hi  = r_is_div ? w_div_hi : w_mul_hi;
    assign w_step_lo  = r_is_div ? w_div_lo : w_mul_lo;
    assign w_prod_fix = r_neg_q ? -{w_step_hi, w_step_lo} : {w_step_hi, w_step_lo};
    assign w_quo_fix  = r_neg_q ? -w_step_lo : w_step_lo;
    assign w_rem_fix  = r_neg_r ? -w_step_hi : w_step_hi;
    assign w_fin_hi   = r_is_div ? w_rem_fix : w_prod_fix[2*XLEN-1:XLEN];
    assign w_fin_lo   = r_is_div ? w_quo_fix : w_prod_fix[XLEN-1:0];
    assign w_last     = (r_cnt == CNT_W'(XLEN - 1));
    assign w_div_zero = r_is_div & (r_opnd == {XLEN{1'b0}});

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_is_div     <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_opnd       <= '0;
            r_src1       <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hi    <= '0;
            r_resp_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_CALC;
                        r_cnt    <= '0;
                        r_is_div <= req_op[1];
                        r_neg_q  <= w_src1_neg ^ w_src2_neg;
                        r_neg_r  <= w_src1_neg;
                        r_src1   <= req_src1;
                        r_hi     <= '0;
                        // MUL: the multiplicand stays put and the multiplier shifts through LO.
                        // DIV: the divisor stays put and the dividend shifts through LO.
                        r_opnd   <= req_op[1] ? w_src2_mag : w_src1_mag;
                        r_lo     <= req_op[1] ? w_src1_mag : w_src2_mag;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else if (w_div_zero) begin
                        r_state      <= S_DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_hi    <= r_src1;
                        r_resp_lo    <= '1;
                    end else if (w_last) begin
                        r_state      <= S_DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_hi    <= w_fin_hi;
                        r_resp_lo    <= w_fin_lo;
                    end else begin
                        r_hi  <= w_step_hi;
                        r_lo  <= w_step_lo;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // A cancel discards the result even when resp_ready is high.
                    if (cancel || resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_hi    = r_resp_hi;
    assign resp_lo    = r_resp_lo;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_exe_muldiv_unit.sv
module tb_exe_muldiv_unit;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        cancel;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_hi;
    logic [31:0] resp_lo;
    logic        busy;

    always #5 clk = ~clk;

    exe_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .cancel     (cancel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hi    (resp_hi),
        .resp_lo    (resp_lo),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {hi, lo}.
    function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p, qq, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin p = 64'(sa * sb); return p; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'd3) return {a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                qq = 64'(q);
                rr = 64'(r);
                return {rr[31:0], qq[31:0]};
            end
        endcase
    endfunction

    // Transaction-level model: response due a fixed number of cycles after
    // accept, held until popped, dropped on cancel or reset.
    logic        m_busy, m_valid;
    int          m_left;
    logic [63:0] m_res;
    logic [31:0] m_hi, m_lo;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_left  <= 0;
        end else if (m_busy) begin
            if (cancel) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
            end else if (m_valid) begin
                if (resp_ready) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b0;
                end
            end else if (m_left == 1) begin
                m_valid <= 1'b1;
                m_hi    <= m_res[63:32];
                m_lo    <= m_res[31:0];
                m_left  <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (req_valid && !cancel) begin
            m_busy <= 1'b1;
            m_res  <= ref_calc(req_op, req_src1, req_src2);
            m_left <= (req_op[1] && req_src2 == 32'd0) ? 1 : XLEN;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("resp_valid", 64'(resp_valid), 64'(m_valid));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("req_ready", 64'(req_ready), 64'(resetn && !m_busy && !cancel));
            if (m_valid) begin
                chk("resp_hi", 64'(resp_hi), 64'(m_hi));
                chk("resp_lo", 64'(resp_lo), 64'(m_lo));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 3));
        req_src1  = $urandom;
        req_src2  = $urandom;
    endtask

    task automatic dir_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int elat, input int hold);
        bit seen = 1'b0;
        send(op, a, b);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin seen = 1'b1; break; end
        end
        chk({nm, "_seen"}, 64'(seen), 64'd1);
        chk({nm, "_lat"}, 64'(cyc - acc_cyc), 64'(elat));
        chk({nm, "_hi"}, 64'(resp_hi), 64'(eh));
        chk({nm, "_lo"}, 64'(resp_lo), 64'(el));
        $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", nm, op, a, b,
                 resp_hi, resp_lo, cyc - acc_cyc);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 64'(resp_valid), 64'd1);
            chk({nm, "_hold_hi"}, 64'(resp_hi), 64'(eh));
            chk({nm, "_hold_lo"}, 64'(resp_lo), 64'(el));
            chk({nm, "_hold_rdy"}, 64'(req_ready), 64'd0);
        end
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_pop_valid"}, 64'(resp_valid), 64'd0);
        chk({nm, "_pop_busy"}, 64'(busy), 64'd0);
        chk({nm, "_pop_rdy"}, 64'(req_ready), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit seen;
        bit done;
        int cancel_at, hold, vcnt;
        logic [1:0]  op;
        logic [31:0] a, b;

        resetn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_src1 = '0; req_src2 = '0;
        cancel = 1'b0; resp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(resp_hi), 64'd0);
        chk("rst_lo", 64'(resp_lo), 64'd0);
        chk("rst_rdy", 64'(req_ready), 64'd0);
        #1 resetn = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_rel_rdy", 64'(req_ready), 64'd1);

        // Hand-computed values pinning the reference arithmetic
        chk("pin_multu", ref_calc(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("pin_mult", ref_calc(2'd0, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("pin_div", ref_calc(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("pin_divu0", ref_calc(2'd3, 32'd7, 32'd0), 64'h0000_0007_FFFF_FFFF);
        chk("pin_divovf", ref_calc(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("pin_divu", ref_calc(2'd3, 32'd100, 32'd7), 64'h0000_0002_0000_000E);

        // Directed cases with literal expectations
        dir_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32, 0);
        dir_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32, 1);
        dir_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, 0);
        dir_op("divu_zero", 2'd3, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1, 0);
        dir_op("div_zero", 2'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 0);
        dir_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32, 0);
        dir_op("multu_hold", 2'd1, 32'd3, 32'd4, 32'h0, 32'h0000_000C, 32, 5);

        // Reset in the middle of a calculation
        send(2'd1, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_valid", 64'(resp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(resp_hi), 64'd0);
        chk("midrst_lo", 64'(resp_lo), 64'd0);
        @(negedge clk);
        #1 resetn = 1'b1;
        dir_op("after_rst", 2'd1, 32'd5, 32'd6, 32'h0, 32'h0000_001E, 32, 0);

        // Cancel in the 10th CALC cycle
        send(2'd2, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_rdy", 64'(req_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        chk("cancel_no_resp", 64'(seen), 64'd0);
        $display("txn cancel_calc op=2 a=00000064 b=00000007 -> dropped");

        // Cancel while idle blocks acceptance
        @(negedge clk);
        #1;
        cancel = 1'b1; req_valid = 1'b1; req_op = 2'd1; req_src1 = 32'd2; req_src2 = 32'd2;
        @(negedge clk);
        chk("idlecan_rdy", 64'(req_ready), 64'd0);
        chk("idlecan_busy", 64'(busy), 64'd0);
        #1;
        cancel = 1'b0; req_valid = 1'b0;
        $display("txn cancel_idle op=1 a=00000002 b=00000002 -> not accepted");

        // Randomized transactions checked by the model
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            cancel_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            hold = int'($urandom_range(0, 3));
            send(op, a, b);
            vcnt = 0;
            done = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (!m_busy) begin done = 1'b1; break; end
                #1;
                cancel     = (k == cancel_at);
                resp_ready = m_valid && (vcnt >= hold);
                if (m_valid) vcnt++;
                req_valid  = 1'($urandom_range(0, 1));
                req_op     = 2'($urandom_range(0, 3));
                req_src1   = $urandom;
                req_src2   = $urandom;
            end
            #1;
            cancel = 1'b0; resp_ready = 1'b0; req_valid = 1'b0;
            chk("rand_complete", 64'(done), 64'd1);
            $display("txn rand%0d op=%0d a=%h b=%h -> hi=%h lo=%h cancel_at=%0d",
                     n, op, a, b, m_res[63:32], m_res[31:0], cancel_at);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
